// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 8-channel TDM serializer.
package tdm_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_mux_mux8.sv
// Combinational 8:1 bit select used to pick the next serial bit from the snapshot.
module mux8
  import tdm_pkg::*;
(
  input  logic [N_CH-1:0]  i_data,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_bit
);

  // Pure bit select; the caller registers the result.
  always_comb begin
    o_bit = i_data[i_sel];
  end

endmodule

// File: rtl/tdm_mux.sv
// 8-channel TDM serializer: snapshots D_IN on START and shifts one channel per cycle onto Y.
module tdm_mux
  import tdm_pkg::*;
#(
  parameter logic CONT = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_CH-1:0]  D_IN,
  input  logic             START,
  output logic             Y,
  output logic [SEL_W-1:0] SEL,
  output logic             VALID,
  output logic             FSYNC,
  output logic             BUSY,
  output logic             DONE
);

  state_t             r_state;
  logic [N_CH-1:0]    r_snap;
  logic [SEL_W-1:0]   r_sel;
  logic               r_y;
  logic               r_valid;
  logic               r_fsync;
  logic               r_busy;
  logic               r_done;

  logic [SEL_W-1:0]   w_sel_inc;
  logic               w_bit_next;

  // Y is registered, so the mux looks one channel ahead of the current SEL.
  assign w_sel_inc = r_sel + 3'd1;

  mux8 u_mux8 (
    .i_data (r_snap),
    .i_sel  (w_sel_inc),
    .o_bit  (w_bit_next)
  );

  // Frame sequencer: state, snapshot and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_snap  <= 8'd0;
      r_sel   <= 3'd0;
      r_y     <= 1'b0;
      r_valid <= 1'b0;
      r_fsync <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_state <= SCAN;
            r_snap  <= D_IN;
            r_sel   <= 3'd0;
            r_y     <= D_IN[0];
            r_valid <= 1'b1;
            r_fsync <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_sel   <= 3'd0;
            r_y     <= 1'b0;
            r_valid <= 1'b0;
            r_fsync <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (r_sel == 3'd7) begin
            // Continuous mode chains the next frame with no gap cycle.
            if ((CONT == 1'b1) && START) begin
              r_snap  <= D_IN;
              r_sel   <= 3'd0;
              r_y     <= D_IN[0];
              r_fsync <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state <= FIN;
              r_sel   <= 3'd0;
              r_y     <= 1'b0;
              r_valid <= 1'b0;
              r_fsync <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_sel   <= w_sel_inc;
            r_y     <= w_bit_next;
            r_fsync <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_sel   <= 3'd0;
          r_y     <= 1'b0;
          r_valid <= 1'b0;
          r_fsync <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= 3'd0;
          r_y     <= 1'b0;
          r_valid <= 1'b0;
          r_fsync <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Y     = r_y;
  assign SEL   = r_sel;
  assign VALID = r_valid;
  assign FSYNC = r_fsync;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule
